// File: rtl/pwm_mc.sv
// Multi-channel PWM with prescaler, edge/center-aligned counting
// and double-buffered duty that applies at period boundaries.
module pwm_mc #(
  parameter int NCH        = 2,
  parameter int DW         = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  enable,
  input  logic                  center_mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [NCH*DW-1:0]     duty,
  input  logic                  duty_load,
  output logic [NCH-1:0]        pwm_out,
  output logic                  period_start,
  output logic                  upd_pending
);

  localparam logic [DW-1:0] MAX = '1;

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [DW-1:0]         cnt_q, cnt_d, cnt_nx;
  logic                  dir_q, dir_d, dir_nx;
  logic                  mode_q, mode_d;
  logic [NCH*DW-1:0]     shadow_q, shadow_d;
  logic [NCH*DW-1:0]     active_q, active_d;
  logic                  pend_q, pend_d;
  logic [NCH-1:0]        pwm_q, pwm_d;
  logic                  ps_q, ps_d;
  logic                  tick, boundary;

  assign tick = enable && (pcnt_q == prescale);

  // dir_q = 1 means counting down (center mode only)
  always_comb begin
    cnt_nx = cnt_q + 1'b1;
    dir_nx = 1'b0;
    if (mode_q) begin
      if (!dir_q) begin
        if (cnt_q == MAX) begin
          cnt_nx = MAX - 1'b1;
          dir_nx = 1'b1;
        end
      end else begin
        cnt_nx = cnt_q - 1'b1;
        dir_nx = 1'b1;
      end
    end
  end

  assign boundary = tick && (cnt_nx == '0);

  always_comb begin
    pcnt_d   = pcnt_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    ps_d     = boundary;
    for (int i = 0; i < NCH; i++)
      pwm_d[i] = enable && (cnt_q < active_q[i*DW +: DW]);
    if (!enable) begin
      pcnt_d   = '0;
      cnt_d    = '0;
      dir_d    = 1'b0;
      mode_d   = center_mode;
      active_d = shadow_q;
      pend_d   = 1'b0;
      if (duty_load) shadow_d = duty;
    end else begin
      // pcnt above a shrunk prescale simply wraps: one long tick
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
      if (tick) begin
        cnt_d = cnt_nx;
        dir_d = dir_nx;
      end
      if (boundary) begin
        dir_d  = 1'b0;
        mode_d = center_mode;
        pend_d = 1'b0;
        if (duty_load) begin
          active_d = duty;
          shadow_d = duty;
        end else if (pend_q) begin
          active_d = shadow_q;
        end
      end else if (duty_load) begin
        shadow_d = duty;
        pend_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      pcnt_q   <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      mode_q   <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
      pwm_q    <= '0;
      ps_q     <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      pwm_q    <= pwm_d;
      ps_q     <= ps_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign upd_pending  = pend_q;

endmodule

// File: tb/tb_pwm_mc.sv
// Randomised bench for pwm_mc against a phase-based reference
// model: the counter value is derived from position in the period.
module tb_pwm_mc;

  localparam int NCH = 2;
  localparam int DW  = 8;
  localparam int PW  = 4;
  localparam int MAX = (1 << DW) - 1;

  logic              clk = 1'b0;
  logic              resetb;
  logic              enable;
  logic              center_mode;
  logic [PW-1:0]     prescale;
  logic [NCH*DW-1:0] duty;
  logic              duty_load;
  logic [NCH-1:0]    pwm_out;
  logic              period_start;
  logic              upd_pending;

  pwm_mc #(.NCH(NCH), .DW(DW), .PRESCALE_W(PW)) dut (
    .clk          (clk),
    .resetb       (resetb),
    .enable       (enable),
    .center_mode  (center_mode),
    .prescale     (prescale),
    .duty         (duty),
    .duty_load    (duty_load),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .upd_pending  (upd_pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model: ph = tick index within the current period
  int m_pc, m_ph, m_mode, m_pend, m_ps;
  int m_pwm[NCH], m_act[NCH], m_shd[NCH];

  function automatic void model_reset();
    m_pc = 0; m_ph = 0; m_mode = 0; m_pend = 0; m_ps = 0;
    for (int i = 0; i < NCH; i++) begin
      m_pwm[i] = 0; m_act[i] = 0; m_shd[i] = 0;
    end
  endfunction

  function automatic int period_len();
    return m_mode ? 2 * MAX : MAX + 1;
  endfunction

  function automatic int cur_cnt();
    if (m_mode && m_ph > MAX) return 2 * MAX - m_ph;
    return m_ph;
  endfunction

  function automatic bit bnd_next();
    return enable && (m_pc == int'(prescale))
           && ((m_ph + 1) % period_len() == 0);
  endfunction

  function automatic int duty_of(int i);
    return int'(duty[i*DW +: DW]);
  endfunction

  function automatic void model_step();
    int c;
    bit b;
    c = cur_cnt();
    b = bnd_next();
    for (int i = 0; i < NCH; i++)
      m_pwm[i] = (enable && c < m_act[i]) ? 1 : 0;
    m_ps = b;
    if (!enable) begin
      m_pc = 0; m_ph = 0; m_pend = 0;
      m_mode = center_mode;
      for (int i = 0; i < NCH; i++) begin
        m_act[i] = m_shd[i];
        if (duty_load) m_shd[i] = duty_of(i);
      end
    end else begin
      if (m_pc == int'(prescale)) begin
        m_pc = 0;
        m_ph = (m_ph + 1) % period_len();
      end else begin
        m_pc = (m_pc + 1) % (1 << PW);
      end
      if (b) begin
        m_mode = center_mode;
        for (int i = 0; i < NCH; i++) begin
          if (duty_load) begin
            m_act[i] = duty_of(i);
            m_shd[i] = duty_of(i);
          end else if (m_pend != 0) begin
            m_act[i] = m_shd[i];
          end
        end
        m_pend = 0;
      end else if (duty_load) begin
        for (int i = 0; i < NCH; i++) m_shd[i] = duty_of(i);
        m_pend = 1;
      end
    end
  endfunction

  task automatic check_all();
    logic [NCH-1:0] ep;
    for (int i = 0; i < NCH; i++) ep[i] = m_pwm[i][0];
    check("pwm_out", 32'(pwm_out), 32'(ep));
    check("period_start", 32'(period_start), 32'(m_ps));
    check("upd_pending", 32'(upd_pending), 32'(m_pend));
  endtask

  function automatic logic [NCH*DW-1:0] rand_duty();
    logic [NCH*DW-1:0] d;
    for (int i = 0; i < NCH; i++)
      case ($urandom_range(0, 5))
        0:       d[i*DW +: DW] = '0;
        1:       d[i*DW +: DW] = '1;
        default: d[i*DW +: DW] = DW'($urandom);
      endcase
    return d;
  endfunction

  logic [NCH*DW-1:0] seg_duty;

  initial begin
    resetb = 1'b0; enable = 1'b0; center_mode = 1'b0;
    prescale = '0; duty = '0; duty_load = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    resetb = 1'b1;
    for (int seg = 0; seg < 12; seg++) begin
      case (seg)
        0: begin seg_duty = {8'h80, 8'h40}; center_mode = 0; prescale = 0; end
        1: begin seg_duty = {8'hFF, 8'h00}; center_mode = 0; prescale = 0; end
        2: begin seg_duty = {8'h80, 8'h80}; center_mode = 1; prescale = 0; end
        3: begin seg_duty = {8'h10, 8'h30}; center_mode = 0; prescale = 3; end
        default: begin
          seg_duty    = rand_duty();
          center_mode = 1'($urandom_range(0, 1));
          prescale    = PW'($urandom_range(0, 3));
        end
      endcase
      for (int cyc = 0; cyc < 3000; cyc++) begin
        enable = !(cyc < 3 || $urandom_range(0, 799) == 0);
        if ($urandom_range(0, 2999) == 0) prescale = PW'($urandom);
        if ($urandom_range(0, 599) == 0) center_mode = ~center_mode;
        duty_load = 1'b0;
        if (cyc == 1) begin
          duty = seg_duty; duty_load = 1'b1;
        end else if ($urandom_range(0, 249) == 0
                     || (bnd_next() && $urandom_range(0, 2) == 0)) begin
          duty = rand_duty(); duty_load = 1'b1;
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        if (seg == 6 && cyc == 1500) begin
          #2 resetb = 1'b0;
          #1;
          check("rst_pwm", 32'(pwm_out), 32'd0);
          check("rst_ps", 32'(period_start), 32'd0);
          check("rst_pend", 32'(upd_pending), 32'd0);
          model_reset();
          duty_load = 1'b0;
          @(posedge clk);
          @(negedge clk);
          check_all();
          resetb = 1'b1;
        end
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
